// File: rtl/up_down_counter_cfg.sv
// Up/down counter with runtime bounds, variable step, wrap or saturate mode,
// synchronous clamped load, terminal-count pulse and saturating event counter.
module up_down_counter_cfg #(
  parameter int N      = 4,
  parameter int STEP_W = 4,
  parameter int EVT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              up_down,
  input  logic              load,
  input  logic [N-1:0]      load_val,
  input  logic [STEP_W-1:0] step,
  input  logic [N-1:0]      min_val,
  input  logic [N-1:0]      max_val,
  input  logic              sat_mode,
  output logic [N-1:0]      count,
  output logic              at_min,
  output logic              at_max,
  output logic              tc,
  output logic [EVT_W-1:0]  evt_cnt,
  output logic              cfg_err
);

  // Wide enough that neither count+step nor min+step can overflow.
  localparam int AW = ((N > STEP_W) ? N : STEP_W) + 1;
  typedef logic [AW-1:0] wide_t;

  wide_t            count_w, step_w, min_w, max_w;
  logic [N-1:0]     count_next;
  logic             tc_next;
  logic [EVT_W-1:0] evt_next;
  logic             event_hit;

  assign count_w = wide_t'(count);
  assign step_w  = wide_t'(step);
  assign min_w   = wide_t'(min_val);
  assign max_w   = wide_t'(max_val);

  assign at_min  = (count == min_val);
  assign at_max  = (count == max_val);
  assign cfg_err = (min_val > max_val);

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
    count_next = count;
    tc_next    = 1'b0;
    evt_next   = evt_cnt;
    event_hit  = 1'b0;

    if (cfg_err) begin
      count_next = count;
    end else if (load) begin
      if (load_val < min_val)      count_next = min_val;
      else if (load_val > max_val) count_next = max_val;
      else                         count_next = load_val;
      evt_next = '0;
    end else if (en && (step != '0)) begin
      if (up_down) begin
        if (count_w + step_w > max_w) begin
          event_hit  = 1'b1;
          count_next = sat_mode ? max_val : min_val;
        end else begin
          count_next = N'(count_w + step_w);
        end
      end else begin
        if (count_w < min_w + step_w) begin
          event_hit  = 1'b1;
          count_next = sat_mode ? min_val : max_val;
        end else begin
          // No event implies step <= count, so this cannot underflow.
          count_next = N'(count_w - step_w);
        end
      end
      if (event_hit) begin
        tc_next  = 1'b1;
        evt_next = (&evt_cnt) ? evt_cnt : evt_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    if (!reset) begin
      count   <= '0;
      tc      <= 1'b0;
      evt_cnt <= '0;
    end else begin
      count   <= count_next;
      tc      <= tc_next;
      evt_cnt <= evt_next;
    end
  end

endmodule

// File: tb/tb_up_down_counter_cfg.sv
// Bench for up_down_counter_cfg: integer reference model compared every
// falling edge, plus directed sequences with hand-computed expectations.
module tb_up_down_counter_cfg;

  localparam int N      = 4;
  localparam int STEP_W = 4;
  localparam int EVT_W  = 8;
  localparam int EVT_MAX = (1 << EVT_W) - 1;

  logic              clk;
  logic              reset;
  logic              en;
  logic              up_down;
  logic              load;
  logic [N-1:0]      load_val;
  logic [STEP_W-1:0] step;
  logic [N-1:0]      min_val;
  logic [N-1:0]      max_val;
  logic              sat_mode;
  logic [N-1:0]      count;
  logic              at_min;
  logic              at_max;
  logic              tc;
  logic [EVT_W-1:0]  evt_cnt;
  logic              cfg_err;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 0;

  up_down_counter_cfg #(.N(N), .STEP_W(STEP_W), .EVT_W(EVT_W)) dut (
    .clk(clk), .reset(reset), .en(en), .up_down(up_down), .load(load),
    .load_val(load_val), .step(step), .min_val(min_val), .max_val(max_val),
    .sat_mode(sat_mode), .count(count), .at_min(at_min), .at_max(at_max),
    .tc(tc), .evt_cnt(evt_cnt), .cfg_err(cfg_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the bounds.
  int m_count = 0;
  int m_evt   = 0;
  bit m_tc    = 0;
  int lo, hi, c, s;
  bit ev;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_count = 0;
      m_tc    = 0;
      m_evt   = 0;
    end else begin
      lo = int'(min_val);
      hi = int'(max_val);
      c  = m_count;
      s  = int'(step);
      ev = 0;
      if (lo > hi) begin
        m_tc = 0;
      end else if (load) begin
        m_count = (int'(load_val) < lo) ? lo : (int'(load_val) > hi) ? hi : int'(load_val);
        m_evt   = 0;
        m_tc    = 0;
      end else if (en && s != 0) begin
        if (up_down) begin
          if (c + s > hi) begin ev = 1; m_count = sat_mode ? hi : lo; end
          else m_count = c + s;
        end else begin
          if (c - s < lo) begin ev = 1; m_count = sat_mode ? lo : hi; end
          else m_count = c - s;
        end
        m_tc = ev;
        if (ev && m_evt < EVT_MAX) m_evt = m_evt + 1;
      end else begin
        m_tc = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_count",   int'(count),   m_count);
      check("model_tc",      int'(tc),      int'(m_tc));
      check("model_evt_cnt", int'(evt_cnt), m_evt);
      check("model_at_min",  int'(at_min),  int'(m_count == int'(min_val)));
      check("model_at_max",  int'(at_max),  int'(m_count == int'(max_val)));
      check("model_cfg_err", int'(cfg_err), int'(min_val > max_val));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_state(input string name, input int e_count, input int e_tc, input int e_evt);
    check({name, "_count"}, int'(count), e_count);
    check({name, "_tc"}, int'(tc), e_tc);
    check({name, "_evt"}, int'(evt_cnt), e_evt);
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; up_down = 1'b1; load = 1'b0; load_val = '0;
    step = '0; min_val = '0; max_val = 4'd15; sat_mode = 1'b0;
    #2 reset = 1'b0;
    #1 chk_en = 1;
    expect_state("reset_init", 0, 0, 0);
    cyc();
    reset = 1'b1;

    // Wrap up, step 3 in [2,10]
    min_val = 4'd2; max_val = 4'd10; step = 4'd3; sat_mode = 1'b0; up_down = 1'b1;
    load = 1'b1; load_val = 4'd2;
    cyc(); expect_state("up_load", 2, 0, 0);
    load = 1'b0; en = 1'b1;
    cyc(); expect_state("up_1", 5, 0, 0);
    cyc(); expect_state("up_2", 8, 0, 0);
    cyc(); expect_state("up_wrap", 2, 1, 1);
    cyc(); expect_state("up_after", 5, 0, 1);

    // Wrap down, step 3
    en = 1'b0; load = 1'b1; load_val = 4'd4; up_down = 1'b0;
    cyc(); expect_state("dn_load", 4, 0, 0);
    load = 1'b0; en = 1'b1;
    cyc(); expect_state("dn_wrap1", 10, 1, 1);
    cyc(); expect_state("dn_1", 7, 0, 1);
    cyc(); expect_state("dn_2", 4, 0, 1);
    cyc(); expect_state("dn_wrap2", 10, 1, 2);

    // Saturate up, step 4, re-firing at the bound
    en = 1'b0; load = 1'b1; load_val = 4'd8; sat_mode = 1'b1; up_down = 1'b1; step = 4'd4;
    cyc(); expect_state("sat_load", 8, 0, 0);
    load = 1'b0; en = 1'b1;
    cyc(); expect_state("sat_hit", 10, 1, 1);
    for (int i = 0; i < 3; i++) begin
      cyc(); check("sat_hold_count", int'(count), 10); check("sat_hold_tc", int'(tc), 1);
    end
    check("sat_evt", int'(evt_cnt), 4);

    // Count above a lowered max, then below a raised min
    max_val = 4'd6; sat_mode = 1'b0; step = 4'd1;
    cyc(); expect_state("oob_up", 2, 1, 5);
    min_val = 4'd4; max_val = 4'd12; up_down = 1'b0;
    cyc(); expect_state("oob_dn", 12, 1, 6);

    // Load priority over en, clamping both ways
    min_val = 4'd2; max_val = 4'd10; load = 1'b1; load_val = 4'd15;
    cyc(); expect_state("load_hi", 10, 0, 0);
    load_val = 4'd0;
    cyc(); expect_state("load_lo", 2, 0, 0);
    load = 1'b0; en = 1'b0;

    // Inverted bounds freeze everything
    min_val = 4'd9; max_val = 4'd3;
    #1 check("cfg_err_set", int'(cfg_err), 1);
    en = 1'b1; load = 1'b1; load_val = 4'd7;
    cyc(); expect_state("cfg_frz1", 2, 0, 0);
    load = 1'b0; up_down = 1'b1;
    cyc(); expect_state("cfg_frz2", 2, 0, 0);

    // Zero step holds
    min_val = 4'd2; max_val = 4'd10; step = 4'd0;
    cyc(); expect_state("step0", 2, 0, 0);

    // min==max: every step is an event; drive evt_cnt to saturation
    min_val = 4'd5; max_val = 4'd5; en = 1'b0; load = 1'b1; load_val = 4'd0;
    cyc(); expect_state("eq_load", 5, 0, 0);
    check("eq_at_min", int'(at_min), 1); check("eq_at_max", int'(at_max), 1);
    load = 1'b0; en = 1'b1; step = 4'd1;
    repeat (255) cyc();
    expect_state("evt_sat", 5, 1, 255);
    up_down = 1'b0;
    repeat (3) cyc();
    expect_state("evt_hold", 5, 1, 255);

    // Asynchronous reset mid-count at 7
    en = 1'b0; min_val = 4'd0; max_val = 4'd7; sat_mode = 1'b1; up_down = 1'b1;
    load = 1'b1; load_val = 4'd7;
    cyc();
    load = 1'b0; en = 1'b1;
    cyc(); expect_state("pre_rst", 7, 1, 1);
    #2 reset = 1'b0;
    #1 expect_state("async_rst", 0, 0, 0);
    cyc(); expect_state("rst_held", 0, 0, 0);
    reset = 1'b1;
    cyc(); expect_state("rst_release", 1, 0, 0);

    repeat (2) cyc();
    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
